// File: rtl/sr_universal_register.sv
// ---------------------------------------------------------------------------
// sr_universal_register
//
// WIDTH-bit edge-triggered universal register. It replaces the gated D latch
// and NOR SR latch pair with one clocked storage/shift element. Each rising
// edge does three things:
//   1. It picks a mode result from hold, parallel load, shift left or
//      shift right.
//   2. It applies the per-bit set/clear masks. Clear wins where both are set.
//   3. It stores the result and flags whether the stored value changed.
//
// Ports:
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset; q <= RESET_VALUE, changed <= 0
//   en        mode-operation enable; en=0 makes the mode path hold
//   mode      00 hold, 01 load, 10 shift left, 11 shift right
//   d         parallel load data
//   ser_in_l  serial input entering bit 0 on shift left
//   ser_in_r  serial input entering bit WIDTH-1 on shift right
//   set_mask  per-bit synchronous set (applied even when en=0)
//   clr_mask  per-bit synchronous clear (beats set_mask)
//   q         registered state
//   q_n       bitwise complement of q, combinational, so no skew against q
//   ser_out   bit that the current shift mode will discard next (for cascading)
//   changed   registered; high for the cycle after an edge that changed q
// ---------------------------------------------------------------------------
module sr_universal_register #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   input  logic [WIDTH-1:0] set_mask,
   input  logic [WIDTH-1:0] clr_mask,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic             ser_out,
   output logic             changed
);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LOAD  = 2'b01,
      MODE_SHL   = 2'b10,
      MODE_SHR   = 2'b11
   } mode_e;

   mode_e            mode_sel;
   logic [WIDTH-1:0] mode_res;
   logic [WIDTH-1:0] state_d, state_q;
   logic             changed_d, changed_q;

   assign mode_sel = mode_e'(mode);

   // Next-state path. Each mode case reads only its own operands. This means
   // d and the serial inputs can be X while their mode is not selected.
   always_comb begin
      // NOTE: every variable written here gets a default first, so no path
      // can leave it unassigned and infer a latch.
      mode_res = state_q;
      if (en) begin
         case (mode_sel)
            MODE_HOLD: mode_res = state_q;
            MODE_LOAD: mode_res = d;
            MODE_SHL:  mode_res = {state_q[WIDTH-2:0], ser_in_l};
            MODE_SHR:  mode_res = {ser_in_r, state_q[WIDTH-1:1]};
         endcase
      end
      // Clear is applied last, so a bit with both masks set ends up 0. This
      // is how the forbidden SR state is resolved.
      state_d   = (mode_res | set_mask) & ~clr_mask;
      changed_d = (state_d != state_q);
   end

   // NOTE: sequential state uses non-blocking assignments only. All flops
   // then sample the same pre-edge values, whatever the process order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= RESET_VALUE;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         changed_q <= changed_d;
      end
   end

   // ser_out depends only on q and mode, not on en. A downstream stage can
   // then see the outgoing bit before it decides whether to shift.
   always_comb begin
      ser_out = 1'b0;
      case (mode_sel)
         MODE_SHL: ser_out = state_q[WIDTH-1];
         MODE_SHR: ser_out = state_q[0];
         default:  ser_out = 1'b0;
      endcase
   end

   assign q       = state_q;
   assign q_n     = ~state_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_sr_universal_register.sv
// ---------------------------------------------------------------------------
// tb_sr_universal_register
//
// Directed bench for sr_universal_register. It uses two instances:
//   - the main instance: WIDTH=8, RESET_VALUE=8'hA5
//   - a second instance: WIDTH=2, RESET_VALUE=2'b01, for the narrow shift
//     boundary
// The driver pushes a hand-computed expectation into a queue and raises
// sample_ev. The monitor waits 1 ns, pops the entry and compares it against
// the selected instance.
// ---------------------------------------------------------------------------
module tb_sr_universal_register;

   logic       clock = 1'b0;
   logic       reset_n;

   // Main instance (8 bits)
   logic       en, ser_in_l, ser_in_r;
   logic [1:0] mode;
   logic [7:0] d, set_mask, clr_mask;
   logic [7:0] q, q_n;
   logic       ser_out, changed;

   // Narrow instance (2 bits)
   logic       en2, ser_in_l2, ser_in_r2;
   logic [1:0] mode2;
   logic [1:0] d2, set_mask2, clr_mask2;
   logic [1:0] q2, q_n2;
   logic       ser_out2, changed2;

   always #5 clock = ~clock;

   sr_universal_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
      .clock(clock), .reset_n(reset_n), .en(en), .mode(mode), .d(d),
      .ser_in_l(ser_in_l), .ser_in_r(ser_in_r),
      .set_mask(set_mask), .clr_mask(clr_mask),
      .q(q), .q_n(q_n), .ser_out(ser_out), .changed(changed)
   );

   sr_universal_register #(.WIDTH(2), .RESET_VALUE(2'b01)) dut_w2 (
      .clock(clock), .reset_n(reset_n), .en(en2), .mode(mode2), .d(d2),
      .ser_in_l(ser_in_l2), .ser_in_r(ser_in_r2),
      .set_mask(set_mask2), .clr_mask(clr_mask2),
      .q(q2), .q_n(q_n2), .ser_out(ser_out2), .changed(changed2)
   );

   typedef struct {
      string      name;
      bit         w2;    // 1: compare against the 2-bit instance
      logic [7:0] q;
      logic [7:0] qn;
      logic       ch;
      logic       so;
   } exp_t;

   exp_t exp_q[$];
   event sample_ev;
   int   check_cnt = 0;
   int   pass_cnt  = 0;

   function automatic void check(string name, logic [7:0] actual, logic [7:0] required);
      check_cnt++;
      if (actual === required) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, actual, required);
   endfunction

   // Monitor: pops one expectation per sample request.
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         #1;
         if (exp_q.size() == 0) begin
            check("monitor_underflow", 8'd1, 8'd0);
         end else begin
            e = exp_q.pop_front();
            if (e.w2) begin
               check({e.name, ".q"},       {6'b0, q2},         e.q);
               check({e.name, ".q_n"},     {6'b0, q_n2},       e.qn);
               check({e.name, ".changed"}, {7'b0, changed2},   {7'b0, e.ch});
               check({e.name, ".ser_out"}, {7'b0, ser_out2},   {7'b0, e.so});
            end else begin
               check({e.name, ".q"},       q,                  e.q);
               check({e.name, ".q_n"},     q_n,                e.qn);
               check({e.name, ".changed"}, {7'b0, changed},    {7'b0, e.ch});
               check({e.name, ".ser_out"}, {7'b0, ser_out},    {7'b0, e.so});
            end
         end
      end
   end

   // Push an expectation for the current moment and wait long enough for the
   // monitor to sample it before the driver moves on.
   task automatic expect_now(input string name, input bit w2, input logic [7:0] eq,
                             input logic [7:0] eqn, input logic ech, input logic eso);
      exp_t e;
      e.name = name; e.w2 = w2; e.q = eq; e.qn = eqn; e.ch = ech; e.so = eso;
      exp_q.push_back(e);
      -> sample_ev;
      #2;
   endtask

   task automatic edge_expect(input string name, input bit w2, input logic [7:0] eq,
                              input logic [7:0] eqn, input logic ech, input logic eso);
      @(posedge clock);
      expect_now(name, w2, eq, eqn, ech, eso);
   endtask

   initial begin
      reset_n  = 1'b0;
      en = 1'b0; mode = 2'b00; d = 8'h00; ser_in_l = 1'b0; ser_in_r = 1'b0;
      set_mask = 8'h00; clr_mask = 8'h00;
      en2 = 1'b0; mode2 = 2'b00; d2 = 2'b00; ser_in_l2 = 1'b0; ser_in_r2 = 1'b0;
      set_mask2 = 2'b00; clr_mask2 = 2'b00;

      // Reset state and complement
      @(negedge clock);
      expect_now("reset",    1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0);
      expect_now("reset_w2", 1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) edge_expect("hold_after_reset", 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0);

      // Load and change flag
      @(negedge clock); en = 1'b1; mode = 2'b01; d = 8'h3C;
      edge_expect("load_3c",   1'b0, 8'h3C, 8'hC3, 1'b1, 1'b0);
      @(negedge clock); mode = 2'b00;
      edge_expect("hold_3c",   1'b0, 8'h3C, 8'hC3, 1'b0, 1'b0);
      @(negedge clock); mode = 2'b01;
      edge_expect("reload_3c", 1'b0, 8'h3C, 8'hC3, 1'b0, 1'b0);

      // Enable gating: load requested but en=0
      @(negedge clock); en = 1'b0; mode = 2'b01; d = 8'h00;
      edge_expect("en_gate",   1'b0, 8'h3C, 8'hC3, 1'b0, 1'b0);

      // Shift left chain from 8'h81
      @(negedge clock); en = 1'b1; mode = 2'b01; d = 8'h81;
      edge_expect("load_81",   1'b0, 8'h81, 8'h7E, 1'b1, 1'b0);
      @(negedge clock); mode = 2'b10; ser_in_l = 1'b1;
      expect_now("shl_pre",    1'b0, 8'h81, 8'h7E, 1'b1, 1'b1);
      edge_expect("shl_1",     1'b0, 8'h03, 8'hFC, 1'b1, 1'b0);
      edge_expect("shl_2",     1'b0, 8'h07, 8'hF8, 1'b1, 1'b0);

      // Shift right from 8'h81
      @(negedge clock); mode = 2'b01; d = 8'h81;
      edge_expect("load_81b",  1'b0, 8'h81, 8'h7E, 1'b1, 1'b0);
      @(negedge clock); mode = 2'b11; ser_in_r = 1'b0;
      expect_now("shr_pre",    1'b0, 8'h81, 8'h7E, 1'b1, 1'b1);
      edge_expect("shr_1",     1'b0, 8'h40, 8'hBF, 1'b1, 1'b0);

      // Mask precedence
      @(negedge clock); mode = 2'b01; d = 8'h00;
      edge_expect("load_00",   1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
      @(negedge clock); en = 1'b0; mode = 2'b00; set_mask = 8'hF0; clr_mask = 8'h30;
      edge_expect("mask_en0",  1'b0, 8'hC0, 8'h3F, 1'b1, 1'b0);
      @(negedge clock); en = 1'b1; mode = 2'b01; d = 8'hFF; set_mask = 8'h00; clr_mask = 8'h01;
      edge_expect("load_clr",  1'b0, 8'hFE, 8'h01, 1'b1, 1'b0);
      @(negedge clock); d = 8'h12; set_mask = 8'hFF; clr_mask = 8'h00;
      edge_expect("load_set",  1'b0, 8'hFF, 8'h00, 1'b1, 1'b0);
      @(negedge clock); set_mask = 8'hFF; clr_mask = 8'hFF;
      edge_expect("set_clr",   1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);

      // Reset mid-shift
      @(negedge clock); set_mask = 8'h00; clr_mask = 8'h00; d = 8'h3C;
      edge_expect("load_3c_b", 1'b0, 8'h3C, 8'hC3, 1'b1, 1'b0);
      @(negedge clock); mode = 2'b10; ser_in_l = 1'b0;
      edge_expect("shl_78",    1'b0, 8'h78, 8'h87, 1'b1, 1'b0);
      @(negedge clock); reset_n = 1'b0;
      expect_now("rst_mid",    1'b0, 8'hA5, 8'h5A, 1'b0, 1'b1);
      reset_n = 1'b1;
      edge_expect("shl_post",  1'b0, 8'h4A, 8'hB5, 1'b1, 1'b0);

      // Unused inputs at X are ignored
      @(negedge clock); mode = 2'b00; d = 'x; ser_in_l = 1'bx; ser_in_r = 1'bx;
      edge_expect("hold_x",    1'b0, 8'h4A, 8'hB5, 1'b0, 1'b0);
      @(negedge clock); mode = 2'b10; ser_in_l = 1'b1;
      edge_expect("shl_x",     1'b0, 8'h95, 8'h6A, 1'b1, 1'b1);

      // WIDTH=2 shifts
      @(negedge clock); en2 = 1'b1; mode2 = 2'b10; ser_in_l2 = 1'b1;
      edge_expect("w2_shl",    1'b1, 8'h03, 8'h00, 1'b1, 1'b1);
      @(negedge clock); mode2 = 2'b11; ser_in_r2 = 1'b0;
      edge_expect("w2_shr1",   1'b1, 8'h01, 8'h02, 1'b1, 1'b1);
      edge_expect("w2_shr2",   1'b1, 8'h00, 8'h03, 1'b1, 1'b0);

      // Bounded drain of the scoreboard
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
      check("scoreboard_drain", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
